keypad_lock_ctrl: RTL and testbench

- Sequencing controller for the keypad code-entry datapath.
- Consumes the 5-bit encoded key word (bit4 = key valid, bits3:0 = BCD digit) and edge-detects presses.
- Shifts accepted digits into an entry register, compares them against a stored code, and drives unlock/alarm.
- Owns code re-programming (allowed only while unlocked) and the failed-attempt lockout.

---
 rtl/keypad_lock_ctrl_if.sv | 45 ++++
 rtl/keypad_lock_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_keypad_lock_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/keypad_lock_ctrl_if.sv
// rtl/keypad_lock_ctrl_if.sv - Signal bundle between a keypad front end and keypad_lock_ctrl
// Purpose: carries the encoded key word and mode request into the lock
//   controller and its status outputs back out.
// Signals:
//   key_in[4:0]    encoded key word, bit4 = key valid, bits3:0 = BCD digit
//   mode           0 = normal, 1 = program request (honoured only in OPEN)
//   unlock         high throughout OPEN
//   alarm          high throughout LOCKOUT
//   prog_done      one-cycle pulse when a new code is stored
//   state_out[2:0] current controller state
//   digit_cnt[3:0] digits accepted in the current entry
//   fail_cnt[3:0]  consecutive failed attempts
// Modports: master drives key_in/mode, slave (the controller) drives status.
interface keypad_lock_ctrl_if;
  logic [4:0] key_in;
  logic       mode;
  logic       unlock;
  logic       alarm;
  logic       prog_done;
  logic [2:0] state_out;
  logic [3:0] digit_cnt;
  logic [3:0] fail_cnt;

  modport master (
    output key_in,
    output mode,
    input  unlock,
    input  alarm,
    input  prog_done,
    input  state_out,
    input  digit_cnt,
    input  fail_cnt
  );

  modport slave (
    input  key_in,
    input  mode,
    output unlock,
    output alarm,
    output prog_done,
    output state_out,
    output digit_cnt,
    output fail_cnt
  );
endinterface

// File: rtl/keypad_lock_ctrl.sv
// rtl/keypad_lock_ctrl.sv - Keypad code-entry sequencing controller with unlock, re-programming and lockout
// Purpose: edge-detects key presses, collects CODE_LEN digits, compares them
//   against the stored code and drives unlock/alarm. While unlocked a press
//   with mode=1 starts re-programming of the stored code. MAX_FAIL wrong codes
//   in a row start a lockout during which all keys are ignored.
// Ports:
//   clk  rising-edge system clock
//   rst  synchronous active-low reset
//   bus  keypad_lock_ctrl_if.slave: key_in, mode in; unlock, alarm,
//        prog_done, state_out, digit_cnt, fail_cnt out
// Optional feature: define ENTRY_TIMEOUT_EN to abort COLLECT/PROG back to IDLE
//   after TIMEOUT_CYCLES cycles without an accepted key.
module keypad_lock_ctrl #(
  parameter int CODE_LEN       = 3,
  parameter int MAX_FAIL       = 3,
  parameter int OPEN_CYCLES    = 32,
  parameter int LOCKOUT_CYCLES = 64,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic              clk,
  input  logic              rst,
  keypad_lock_ctrl_if.slave bus
);

  // One shared cycle counter serves OPEN, LOCKOUT and the entry timeout;
  // the three uses never overlap in time.
  localparam int TMR_MAX_OL = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
  localparam int TMR_MAX    = (TIMEOUT_CYCLES > TMR_MAX_OL) ? TIMEOUT_CYCLES : TMR_MAX_OL;
  localparam int TW         = $clog2(TMR_MAX + 1);
  localparam int EW         = CODE_LEN * 4;

  localparam logic [3:0]    LEN4      = 4'(CODE_LEN);
  localparam logic [3:0]    FAIL4     = 4'(MAX_FAIL);
  localparam logic [TW-1:0] OPEN_LAST = TW'(OPEN_CYCLES - 1);
  localparam logic [TW-1:0] LOCK_LAST = TW'(LOCKOUT_CYCLES - 1);
  localparam logic [TW-1:0] TMR_ONE   = TW'(1);
`ifdef ENTRY_TIMEOUT_EN
  localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT_CYCLES - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_CHECK   = 3'd2,
    S_OPEN    = 3'd3,
    S_PROG    = 3'd4,
    S_LOCKOUT = 3'd5
  } state_t;

  state_t        state, state_d;
  logic          key_vld_q;          // valid bit of last cycle's key word
  logic [EW-1:0] entry, entry_d;     // digit i lives at entry[4*i +: 4]
  logic [EW-1:0] code, code_d;
  logic [3:0]    digit_cnt, digit_cnt_d;
  logic [3:0]    fail_cnt, fail_cnt_d;
  logic [TW-1:0] tmr, tmr_d;

  logic          accept;
  logic [3:0]    digit;
  logic [EW-1:0] entry_first;        // entry with the digit written at index 0
  logic [EW-1:0] entry_ins;          // entry with the digit written at index digit_cnt

  // Only the rising edge of the valid bit counts, so a held key gives one
  // accept. Non-BCD digits still move key_vld_q, so they also mask a
  // following press until the key is released.
  assign digit  = bus.key_in[3:0];
  assign accept = bus.key_in[4] & ~key_vld_q & (digit <= 4'd9);

  assign entry_first = {entry[EW-1:4], digit};

  always_comb begin
    entry_ins = entry;
    for (int i = 0; i < CODE_LEN; i++) begin
      if (digit_cnt == 4'(i)) entry_ins[4*i +: 4] = digit;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      key_vld_q <= 1'b0;
      entry     <= '0;
      code      <= '0;
      digit_cnt <= '0;
      fail_cnt  <= '0;
      tmr       <= '0;
    end else begin
      state     <= state_d;
      key_vld_q <= bus.key_in[4];
      entry     <= entry_d;
      code      <= code_d;
      digit_cnt <= digit_cnt_d;
      fail_cnt  <= fail_cnt_d;
      tmr       <= tmr_d;
    end
  end

  always_comb begin
    state_d     = state;
    entry_d     = entry;
    code_d      = code;
    digit_cnt_d = digit_cnt;
    fail_cnt_d  = fail_cnt;
    tmr_d       = tmr;

    case (state)
      S_IDLE: begin
        if (accept) begin
          entry_d     = entry_first;
          digit_cnt_d = 4'd1;
          tmr_d       = '0;
          state_d     = S_COLLECT;
        end
      end

      S_COLLECT: begin
        if (accept) begin
          entry_d     = entry_ins;
          digit_cnt_d = digit_cnt + 4'd1;
          tmr_d       = '0;
          if (digit_cnt + 4'd1 == LEN4) state_d = S_CHECK;
        end
`ifdef ENTRY_TIMEOUT_EN
        else if (tmr == IDLE_LAST) begin
          state_d     = S_IDLE;
          digit_cnt_d = '0;
          tmr_d       = '0;
        end else begin
          tmr_d = tmr + TMR_ONE;
        end
`endif
      end

      S_CHECK: begin
        digit_cnt_d = '0;
        tmr_d       = '0;
        if (entry == code) begin
          fail_cnt_d = '0;
          state_d    = S_OPEN;
        end else if (fail_cnt + 4'd1 >= FAIL4) begin
          // Lockout is entered in the same step that the count saturates.
          fail_cnt_d = FAIL4;
          state_d    = S_LOCKOUT;
        end else begin
          fail_cnt_d = fail_cnt + 4'd1;
          state_d    = S_IDLE;
        end
      end

      S_OPEN: begin
        if (accept && bus.mode) begin
          entry_d     = entry_first;
          digit_cnt_d = 4'd1;
          tmr_d       = '0;
          state_d     = S_PROG;
        end else if (tmr == OPEN_LAST) begin
          tmr_d   = '0;
          state_d = S_IDLE;
        end else begin
          tmr_d = tmr + TMR_ONE;
        end
      end

      S_PROG: begin
        // A full entry spends one cycle here with digit_cnt == CODE_LEN;
        // that is the prog_done cycle, and the copy happens at its end.
        if (digit_cnt == LEN4) begin
          code_d      = entry;
          digit_cnt_d = '0;
          tmr_d       = '0;
          state_d     = S_IDLE;
        end else if (accept) begin
          entry_d     = entry_ins;
          digit_cnt_d = digit_cnt + 4'd1;
          tmr_d       = '0;
        end
`ifdef ENTRY_TIMEOUT_EN
        else if (tmr == IDLE_LAST) begin
          state_d     = S_IDLE;
          digit_cnt_d = '0;
          tmr_d       = '0;
        end else begin
          tmr_d = tmr + TMR_ONE;
        end
`endif
      end

      S_LOCKOUT: begin
        if (tmr == LOCK_LAST) begin
          fail_cnt_d = '0;
          tmr_d      = '0;
          state_d    = S_IDLE;
        end else begin
          tmr_d = tmr + TMR_ONE;
        end
      end

      default: begin
        state_d     = S_IDLE;
        digit_cnt_d = '0;
        tmr_d       = '0;
      end
    endcase
  end

  assign bus.unlock    = (state == S_OPEN);
  assign bus.alarm     = (state == S_LOCKOUT);
  assign bus.prog_done = (state == S_PROG) && (digit_cnt == LEN4);
  assign bus.state_out = state;
  assign bus.digit_cnt = digit_cnt;
  assign bus.fail_cnt  = fail_cnt;

endmodule

// File: tb/tb_keypad_lock_ctrl.sv
// tb/tb_keypad_lock_ctrl.sv - Scoreboard bench for keypad_lock_ctrl against an entry-level lock model
module tb_keypad_lock_ctrl;
  localparam int CL = 3;
  localparam int MF = 3;
  localparam int OC = 32;
  localparam int LC = 64;
  localparam int TC = 256;

  localparam int EV_FAIL = 0;
  localparam int EV_OPEN = 1;
  localparam int EV_LOCK = 2;
  localparam int EV_PROG = 3;

  typedef int code_t [CL];
  typedef struct {
    int kind;
    int fcnt;
    int len;
    int post;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  keypad_lock_ctrl_if bus();

  keypad_lock_ctrl #(
    .CODE_LEN(CL),
    .MAX_FAIL(MF),
    .OPEN_CYCLES(OC),
    .LOCKOUT_CYCLES(LC),
    .TIMEOUT_CYCLES(TC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int    errors = 0;
  int    checks = 0;
  ev_t   exp_q[$];
  code_t mcode;
  int    mfails = 0;
  bit    mon_en = 1'b0;

  task automatic check_eq(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic push(input int k, input int f, input int l, input int p);
    ev_t e;
    e.kind = k; e.fcnt = f; e.len = l; e.post = p;
    exp_q.push_back(e);
  endtask

  task automatic sb_event(input int k, input int f, input int l, input int p);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL sb_unexpected: got kind=%0d fcnt=%0d len=%0d post=%0d, want no event", k, f, l, p);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.fcnt != f || (e.len >= 0 && e.len != l) || (e.post >= 0 && e.post != p)) begin
        errors++;
        $display("FAIL sb_event: got kind=%0d fcnt=%0d len=%0d post=%0d, want kind=%0d fcnt=%0d len=%0d post=%0d",
                 k, f, l, p, e.kind, e.fcnt, e.len, e.post);
      end
    end
  endtask

  function automatic bit same(input code_t a, input code_t b);
    bit r = 1'b1;
    for (int i = 0; i < CL; i++) if (a[i] != b[i]) r = 1'b0;
    return r;
  endfunction

  // Reference model: one complete code entry in, expected output events out.
  // res: 0 = wrong code, 1 = unlocked, 2 = lockout.
  task automatic model_entry(input code_t d, input bit keep_open, input bit commit,
                             input code_t nc, output int res);
    if (same(d, mcode)) begin
      mfails = 0;
      push(EV_OPEN, 0, keep_open ? -1 : OC, 0);
      if (commit) begin
        push(EV_PROG, 0, 1, 0);
        mcode = nc;
      end
      res = 1;
    end else begin
      mfails++;
      if (mfails >= MF) begin
        push(EV_LOCK, MF, LC, 0);
        mfails = 0;
        res = 2;
      end else begin
        push(EV_FAIL, mfails, -1, -1);
        res = 0;
      end
    end
  endtask

  // Called and returns on a falling edge.
  task automatic press(input int d, input bit m, input int hold, input int rel);
    bus.key_in = {1'b1, 4'(d)};
    bus.mode   = m;
    repeat (hold) @(negedge clk);
    bus.key_in = {1'b0, 4'($urandom_range(0, 15))};
    bus.mode   = 1'($urandom_range(0, 1));
    repeat (rel) @(negedge clk);
  endtask

  task automatic rpress(input int d, input bit m);
    press(d, m, $urandom_range(1, 3), $urandom_range(1, 3));
  endtask

  task automatic enter_code(input code_t d, input bit noise);
    for (int i = 0; i < CL; i++) begin
      if (noise && $urandom_range(0, 3) == 0)
        rpress($urandom_range(10, 15), 1'($urandom_range(0, 1)));
      rpress(d[i], 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic enter_prog(input code_t nc);
    rpress(nc[0], 1'b1);
    for (int i = 1; i < CL; i++) rpress(nc[i], 1'($urandom_range(0, 1)));
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    repeat (2) @(negedge clk);
    while (!(bus.state_out == 3'd0 && !bus.unlock && !bus.alarm) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: state=%0d after 400 cycles, want 0", name, bus.state_out);
    end
  endtask

  task automatic run_entry(input code_t d, input bit prog, input code_t nc, input bit noise);
    int res;
    model_entry(d, prog, prog, nc, res);
    enter_code(d, noise);
    if (res == 1) begin
      if (prog) enter_prog(nc);
      else repeat ($urandom_range(0, 2)) rpress($urandom_range(0, 9), 1'b0);
    end else if (res == 2) begin
      repeat (3) rpress($urandom_range(0, 9), 1'($urandom_range(0, 1)));
    end
    wait_idle("entry");
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_state"}, int'(bus.state_out), 0);
    check_eq({tag, "_unlock"}, int'(bus.unlock), 0);
    check_eq({tag, "_alarm"}, int'(bus.alarm), 0);
    check_eq({tag, "_prog_done"}, int'(bus.prog_done), 0);
    check_eq({tag, "_digit_cnt"}, int'(bus.digit_cnt), 0);
    check_eq({tag, "_fail_cnt"}, int'(bus.fail_cnt), 0);
  endtask

  // Monitor: turns output activity into events and checks them against the queue.
  logic [2:0] p_state = 3'd0;
  logic       p_unlock = 1'b0;
  logic       p_alarm = 1'b0;
  logic       p_pd = 1'b0;
  int u_len = 0, u_f = 0, a_len = 0, a_f = 0, pd_len = 0, chk_run = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (p_state == 3'd2 && bus.state_out != 3'd2) begin
          check_eq("check_len", chk_run, 1);
          chk_run = 0;
          if (bus.state_out == 3'd0) sb_event(EV_FAIL, int'(bus.fail_cnt), -1, -1);
        end
        if (bus.state_out == 3'd2) chk_run++;

        if (bus.unlock) begin
          if (!p_unlock) begin u_len = 1; u_f = int'(bus.fail_cnt); end
          else u_len++;
        end else if (p_unlock) begin
          sb_event(EV_OPEN, u_f, u_len, int'(bus.fail_cnt));
        end

        if (bus.alarm) begin
          if (!p_alarm) begin a_len = 1; a_f = int'(bus.fail_cnt); end
          else a_len++;
        end else if (p_alarm) begin
          sb_event(EV_LOCK, a_f, a_len, int'(bus.fail_cnt));
        end

        if (bus.prog_done) pd_len = p_pd ? pd_len + 1 : 1;
        else if (p_pd) sb_event(EV_PROG, int'(bus.fail_cnt), pd_len, int'(bus.state_out));

        p_state  = bus.state_out;
        p_unlock = bus.unlock;
        p_alarm  = bus.alarm;
        p_pd     = bus.prog_done;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within 500000 ns");
    $fatal(1);
  end

  initial begin
    code_t z;
    code_t c;
    code_t nc;
    int    res;
    int    k;
    int    idx;

    z = '{0, 0, 0};
    bus.key_in = 5'd0;
    bus.mode   = 1'b0;
    rst        = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    check_reset_outputs("reset");
    mcode  = z;
    mfails = 0;
    mon_en = 1'b1;

    // Default code 000 unlocks for the full open window.
    model_entry(z, 1'b0, 1'b0, z, res);
    for (int i = 0; i < CL; i++) press(0, 1'b0, 3, 2);
    wait_idle("open000");

    // A held key is accepted once.
    c = '{5, 0, 0};
    c[1] = $urandom_range(0, 9);
    c[2] = $urandom_range(0, 9);
    model_entry(c, 1'b0, 1'b0, z, res);
    press(5, 1'b0, 20, 2);
    check_eq("held_digit_cnt", int'(bus.digit_cnt), 1);
    check_eq("held_state", int'(bus.state_out), 1);
    for (int i = 1; i < CL; i++) rpress(c[i], 1'b0);
    wait_idle("held");
    run_entry(z, 1'b0, z, 1'b0);

    // Three wrong codes lead to lockout; presses during lockout are ignored.
    c = '{1, 2, 3};
    repeat (MF) run_entry(c, 1'b0, z, 1'b0);
    check_eq("post_lock_fail_cnt", int'(bus.fail_cnt), mfails);
    check_eq("post_lock_state", int'(bus.state_out), 0);

    // Re-program to 749, old code then fails and new code opens.
    nc = '{7, 4, 9};
    run_entry(z, 1'b1, nc, 1'b0);
    run_entry(z, 1'b0, z, 1'b0);
    run_entry(nc, 1'b0, z, 1'b0);

    // Reset in the middle of programming restores code 000.
    model_entry(mcode, 1'b1, 1'b0, z, res);
    enter_code(mcode, 1'b0);
    rpress($urandom_range(0, 9), 1'b1);
    rpress($urandom_range(0, 9), 1'b0);
    check_eq("prog_mid_state", int'(bus.state_out), 4);
    check_eq("prog_mid_digit_cnt", int'(bus.digit_cnt), 2);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    mcode  = z;
    mfails = 0;
    check_reset_outputs("midreset");
    run_entry(z, 1'b0, z, 1'b0);

    // Randomised mix of correct, reprogramming, near-miss and random entries.
    for (int it = 0; it < 14; it++) begin
      k = $urandom_range(0, 3);
      for (int i = 0; i < CL; i++) nc[i] = $urandom_range(0, 9);
      c = mcode;
      if (k == 2) begin
        idx = $urandom_range(0, CL - 1);
        c[idx] = (c[idx] + 1 + $urandom_range(0, 8)) % 10;
      end else if (k == 3) begin
        for (int i = 0; i < CL; i++) c[i] = $urandom_range(0, 9);
      end
      run_entry(c, (k == 1), nc, 1'b1);
    end

    // Idle entry: aborts with the timeout feature, waits forever without it.
    if (mfails == 0) begin
      c = mcode;
      c[0] = (c[0] + 1) % 10;
      run_entry(c, 1'b0, z, 1'b0);
    end
    c[0] = 4;
    c[1] = $urandom_range(0, 9);
    c[2] = $urandom_range(0, 9);
    press(4, 1'b0, 3, 2);
    repeat (TC + 4) @(negedge clk);
`ifdef ENTRY_TIMEOUT_EN
    check_eq("timeout_state", int'(bus.state_out), 0);
    check_eq("timeout_digit_cnt", int'(bus.digit_cnt), 0);
    check_eq("timeout_fail_cnt", int'(bus.fail_cnt), mfails);
`else
    check_eq("no_timeout_state", int'(bus.state_out), 1);
    check_eq("no_timeout_digit_cnt", int'(bus.digit_cnt), 1);
    check_eq("no_timeout_fail_cnt", int'(bus.fail_cnt), mfails);
    model_entry(c, 1'b0, 1'b0, z, res);
    for (int i = 1; i < CL; i++) rpress(c[i], 1'b0);
    wait_idle("no_timeout");
`endif

    repeat (4) @(negedge clk);
    check_eq("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
